// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - Oversampling UART receiver front end, 8N1 (8E1 with UART_RX_PARITY_EN)
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop bits).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   uart_data  out  last good byte, LSB received first
//   data_valid out  one-cycle strobe, uart_data updated this cycle
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   parity_err out  one-cycle strobe, parity mismatch (constant 0 without the macro)

module uart_rx_byte #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV   = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic [1:0]       boot_cnt_q, boot_cnt_d;
    logic             rx_s;
    logic             tick;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    assign rx_s = rx_sync_q;
    assign tick = (div_cnt_q == DIV_LAST);

    // The synchronizer needs two clocks after reset before rx_s reflects the
    // line; boot_cnt_q == 2 marks the first meaningful sample, where a line
    // that is already low must not be mistaken for a start edge.
    assign boot_cnt_d = (boot_cnt_q == 2'd3) ? boot_cnt_q : boot_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (boot_cnt_q == 2'd2 && !rx_s) begin
                    state_d = S_BREAK;
                end else if (boot_cnt_q == 2'd3 && !rx_s) begin
                    // Restart the baud divider so ticks are phase-aligned to the start edge.
                    state_d   = S_START;
                    div_cnt_d = '0;
                    smp_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (smp_cnt_q == HALF_LAST) begin
                        smp_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (smp_cnt_q == OS_LAST) begin
                        smp_cnt_d = '0;
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (smp_cnt_q == OS_LAST) begin
                        smp_cnt_d = '0;
                        par_d     = rx_s;
                        state_d   = S_STOP;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (smp_cnt_q == OS_LAST) begin
                        smp_cnt_d = '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            // Even parity: data plus parity bit must hold an even number of ones.
                            if (^{shift_q, par_q}) begin
                                perr_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
`else
                            data_d  = shift_q;
                            valid_d = 1'b1;
`endif
                            // Leaving at mid-stop-bit gives half a bit of margin for a back-to-back start.
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            div_cnt_q  <= '0;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            boot_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            div_cnt_q  <= div_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            boot_cnt_q <= boot_cnt_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign uart_data  = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - Directed self-checking bench for uart_rx_byte at default parameters

module tb_uart_rx_byte;

    localparam int BIT = 864;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT   = 8211 + (PAR_EN ? BIT : 0);
    localparam int FRAME = (PAR_EN ? 11 : 10) * BIT;
    localparam int TOL   = 54;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] uart_data;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;

    uart_rx_byte dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .uart_data  (uart_data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid = 0, n_ferr = 0, n_perr = 0, viol = 0;
    int         last_valid_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            last_data = uart_data;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if ({1'b0, data_valid} + {1'b0, frame_err} + {1'b0, parity_err} > 2'd1) viol++;
        if (prev_strobe && (data_valid || frame_err || parity_err)) viol++;
        prev_strobe = data_valid | frame_err | parity_err;
    end

    int checks = 0;
    int failures = 0;
    int start_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (PAR_EN) begin
            rx = par;
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d, input logic stop,
                                input logic par, input int dv, input int fe, input int pe,
                                input logic [7:0] exp_data);
        int bv, bf, bp;
        bv = n_valid;
        bf = n_ferr;
        bp = n_perr;
        send_frame(d, stop, par);
        chk({name, "_valid"}, n_valid - bv, dv);
        chk({name, "_frame_err"}, n_ferr - bf, fe);
        chk({name, "_parity_err"}, n_perr - bp, pe);
        chk({name, "_data"}, int'(uart_data), int'(exp_data));
        if (dv == 1) chk_range({name, "_latency"}, last_valid_cyc - start_cyc, LAT - TOL, LAT + TOL);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_data"}, int'(uart_data), 0);
        chk({name, "_valid"}, int'(data_valid), 0);
        chk({name, "_frame_err"}, int'(frame_err), 0);
        chk({name, "_parity_err"}, int'(parity_err), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par;
        int         dv;
        int         fe;
        int         pe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int snap, prev_vc;

        // Single byte, then three back-to-back bytes (parity values are even parity).
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 1, 0, 0, 8'h11};
        tbl[2] = '{8'h22, 1'b1, 1'b0, 1, 0, 0, 8'h22};
        tbl[3] = '{8'h33, 1'b1, 1'b0, 1, 0, 0, 8'h33};

        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            prev_vc = last_valid_cyc;
            expect_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop, tbl[i].par,
                         tbl[i].dv, tbl[i].fe, tbl[i].pe, tbl[i].exp_data);
            if (i > 0) chk_range($sformatf("vec%0d_spacing", i), last_valid_cyc - prev_vc,
                                 FRAME - TOL, FRAME + TOL);
        end

        // Short glitch: no strobe, then a clean byte.
        snap = n_valid + n_ferr + n_perr;
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (1000) @(negedge clk);
        chk("glitch_strobes", n_valid + n_ferr + n_perr - snap, 0);
        expect_frame("after_glitch", 8'h5A, 1'b1, 1'b0, 1, 0, 0, 8'h5A);

        // Stop bit low followed by a held-low line.
        expect_frame("framing", 8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'h5A);
        snap = n_valid + n_ferr + n_perr;
        rx = 1'b0;
        repeat (2000) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("break_strobes", n_valid + n_ferr + n_perr - snap, 0);
        expect_frame("after_break", 8'h3C, 1'b1, 1'b0, 1, 0, 0, 8'h3C);

        // Reset 4000 clk into 0xFF, released with the line idle.
        snap = n_valid + n_ferr + n_perr;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4000 - BIT) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("mid_reset");
        rst = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("reset_strobes", n_valid + n_ferr + n_perr - snap, 0);
        chk("reset_data_hold", int'(uart_data), 0);
        expect_frame("after_reset", 8'h81, 1'b1, 1'b0, 1, 0, 0, 8'h81);

`ifdef UART_RX_PARITY_EN
        expect_frame("parity_good", 8'h07, 1'b1, 1'b1, 1, 0, 0, 8'h07);
        expect_frame("parity_bad", 8'h07, 1'b1, 1'b0, 0, 0, 1, 8'h07);
`endif

        repeat (20) @(negedge clk);
        chk("strobe_exclusive", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
